// File: rtl/lw_sha_padder_if.sv
// Handshake bundle between the word source, the padder and the hash core.
// Word width follows LW_SHA_PADDER_S64_EN (64 bits when defined, 32 otherwise).
interface lw_sha_padder_if #(
`ifdef LW_SHA_PADDER_S64_EN
  parameter int W = 64
`else
  parameter int W = 32
`endif
);
  localparam int NB = W / 8;
  localparam int BW = $clog2(NB) + 1;

  logic          abort_i;
  logic          msg_valid_i;
  logic          msg_ready_o;
  logic [W-1:0]  msg_data_i;
  logic          msg_last_i;
  logic [BW-1:0] msg_bytes_i;
  logic          sha_start_o;
  logic          sha_data_valid_o;
  logic          sha_last_o;
  logic [W-1:0]  sha_data_o;
  logic          sha_abort_o;
  logic          sha_ready_i;
  logic          sha_core_ready_i;
  logic          sha_done_i;
  logic          busy_o;

  // The padder itself.
  modport slave (
    input  abort_i, msg_valid_i, msg_data_i, msg_last_i, msg_bytes_i,
           sha_ready_i, sha_core_ready_i, sha_done_i,
    output msg_ready_o, sha_start_o, sha_data_valid_o, sha_last_o,
           sha_data_o, sha_abort_o, busy_o
  );

  // Source and core seen from outside the padder.
  modport master (
    output abort_i, msg_valid_i, msg_data_i, msg_last_i, msg_bytes_i,
           sha_ready_i, sha_core_ready_i, sha_done_i,
    input  msg_ready_o, sha_start_o, sha_data_valid_o, sha_last_o,
           sha_data_o, sha_abort_o, busy_o
  );
endinterface

// File: rtl/lw_sha_padder.sv
// SHA-2 message padder: adds the 0x80 terminator, zero fill and length field, 16 words/block.
// LW_SHA_PADDER_S64_EN selects 64-bit words (SHA-384/512); otherwise 32-bit words (SHA-224/256).
module lw_sha_padder #(
`ifdef LW_SHA_PADDER_S64_EN
  parameter int W  = 64,
`else
  parameter int W  = 32,
`endif
  parameter int NB = W / 8
) (
  input logic              clk_i,
  input logic              aresetn_i,
  lw_sha_padder_if.slave   bus
);

  localparam int BW = $clog2(NB) + 1;
  localparam int LW = 2 * W;
  localparam logic [W-1:0] TERM_WORD = {8'h80, {(W-8){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          first_q, first_d;
  logic          term_q, term_d;
  logic          extra_q, extra_d;
  logic [3:0]    widx_q, widx_d;
  logic [63:0]   bitlen_q, bitlen_d;

  logic          beat;
  logic          can_load;
  logic          accept;
  logic          msg_full;
  logic [3:0]    nidx;
  logic [W-1:0]  msg_word;
  logic [63:0]   add_bits;
  logic [LW-1:0] len_field;

  assign beat      = valid_q && bus.sha_ready_i;
  assign can_load  = !valid_q || bus.sha_ready_i;
  // Block position the next loaded word will occupy once everything ahead of it has drained.
  assign nidx      = valid_q ? widx_q + 4'd1 : widx_q;
  assign len_field = LW'(bitlen_q);

  assign bus.msg_ready_o = !bus.abort_i &&
                           ((state_q == S_IDLE && !valid_q) ||
                            (state_q == S_DATA && can_load));
  assign accept   = bus.msg_valid_i && bus.msg_ready_o;
  assign msg_full = !bus.msg_last_i || (bus.msg_bytes_i >= BW'(NB));
  assign add_bits = msg_full ? 64'(W) : (64'(bus.msg_bytes_i) << 3);

  // A short final word carries its own terminator; bytes past it are forced to zero.
  always_comb begin
    msg_word = bus.msg_data_i;
    if (!msg_full) begin
      for (int j = 0; j < NB; j++) begin
        if (j == int'(bus.msg_bytes_i)) begin
          msg_word[W-1-8*j -: 8] = 8'h80;
        end else if (j > int'(bus.msg_bytes_i)) begin
          msg_word[W-1-8*j -: 8] = 8'h00;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    first_d  = first_q;
    term_d   = term_q;
    extra_d  = extra_q;
    widx_d   = widx_q;
    bitlen_d = bitlen_q;

    if (beat) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      first_d = 1'b0;
      widx_d  = widx_q + 4'd1;
    end

    case (state_q)
      S_IDLE, S_DATA: begin
        if (accept) begin
          data_d  = msg_word;
          valid_d = 1'b1;
          last_d  = 1'b0;
          term_d  = bus.msg_last_i && msg_full;
          extra_d = bus.msg_last_i && !msg_full && (nidx >= 4'd14);
          if (state_q == S_IDLE) begin
            first_d  = 1'b1;
            bitlen_d = add_bits;
          end else begin
            bitlen_d = bitlen_q + add_bits;
          end
          state_d = bus.msg_last_i ? S_PAD : S_DATA;
        end
      end
      S_PAD: begin
        if (can_load) begin
          valid_d = 1'b1;
          last_d  = 1'b0;
          data_d  = '0;
          // A terminator at word 14/15 leaves no room for the length: spill to one more block.
          if (term_q) begin
            data_d  = TERM_WORD;
            term_d  = 1'b0;
            extra_d = (nidx >= 4'd14);
          end else if (nidx == 4'd0) begin
            extra_d = 1'b0;
          end else if (!extra_q && nidx == 4'd14) begin
            data_d = len_field[LW-1:W];
          end else if (!extra_q && nidx == 4'd15) begin
            data_d  = len_field[W-1:0];
            last_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.sha_done_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort_i) begin
      state_d  = S_IDLE;
      data_d   = '0;
      valid_d  = 1'b0;
      last_d   = 1'b0;
      first_d  = 1'b0;
      term_d   = 1'b0;
      extra_d  = 1'b0;
      widx_d   = 4'd0;
      bitlen_d = 64'd0;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      first_q  <= 1'b0;
      term_q   <= 1'b0;
      extra_q  <= 1'b0;
      widx_q   <= 4'd0;
      bitlen_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      first_q  <= first_d;
      term_q   <= term_d;
      extra_q  <= extra_d;
      widx_q   <= widx_d;
      bitlen_q <= bitlen_d;
    end
  end

  assign bus.sha_data_o       = data_q;
  assign bus.sha_data_valid_o = valid_q;
  assign bus.sha_last_o       = last_q;
  assign bus.sha_start_o      = valid_q && first_q;
  assign bus.sha_abort_o      = bus.abort_i;
  assign bus.busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_lw_sha_padder.sv
// Bench for lw_sha_padder: random messages compared against a byte-level SHA-2 padding model.
// Follows LW_SHA_PADDER_S64_EN for word width, like the design.
module tb_lw_sha_padder;
`ifdef LW_SHA_PADDER_S64_EN
  localparam int W = 64;
`else
  localparam int W = 32;
`endif
  localparam int NB = W / 8;
  localparam int BW = $clog2(NB) + 1;

  logic clk_i = 1'b0;
  logic aresetn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  lw_sha_padder_if #(.W(W)) bus ();

  lw_sha_padder #(.W(W), .NB(NB)) dut (
    .clk_i     (clk_i),
    .aresetn_i (aresetn_i),
    .bus       (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]   msg_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_data[$];
  logic         got_last[$];
  logic         got_start[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setRandomMsg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  // Reference: plain SHA-2 padding on the byte stream, then packed big-endian into words.
  function automatic void buildModel();
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [W-1:0] w;
    p  = msg_q;
    bl = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % (16 * NB) != 14 * NB) p.push_back(8'h00);
    for (int k = 2 * NB - 1; k >= 0; k--) p.push_back(8'(bl >> (8 * k)));
    exp_q.delete();
    for (int i = 0; i < p.size(); i += NB) begin
      w = '0;
      for (int j = 0; j < NB; j++) w = (w << 8) | W'(p[i+j]);
      exp_q.push_back(w);
    end
  endfunction

  task automatic applyStimulus(input string name, input bit rnd_ready,
                               input bit rnd_valid, input bit check_gap);
    int           len;
    int           nwords;
    int           wi;
    int           cyc;
    int           bubbles;
    int           idx;
    bit           prev_stall;
    bit           lat_pending;
    logic [W-1:0] prev_data;
    logic [W-1:0] w;
    logic [7:0]   b;
    len         = msg_q.size();
    nwords      = (len == 0) ? 1 : (len + NB - 1) / NB;
    wi          = 0;
    cyc         = 0;
    bubbles     = 0;
    prev_stall  = 1'b0;
    lat_pending = 1'b0;
    prev_data   = '0;
    buildModel();
    got_data.delete();
    got_last.delete();
    got_start.delete();

    while (got_data.size() < exp_q.size() && cyc < 3000) begin
      @(negedge clk_i);
      bus.sha_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wi < nwords && (!rnd_valid || $urandom_range(0, 3) != 0)) begin
        w = '0;
        for (int j = 0; j < NB; j++) begin
          idx = wi * NB + j;
          b   = (idx < len) ? msg_q[idx] : 8'($urandom);
          w   = (w << 8) | W'(b);
        end
        bus.msg_valid_i = 1'b1;
        bus.msg_data_i  = w;
        bus.msg_last_i  = (wi == nwords - 1);
        bus.msg_bytes_i = (wi == nwords - 1) ? BW'(len - wi * NB) : BW'($urandom);
      end else begin
        bus.msg_valid_i = 1'b0;
        bus.msg_data_i  = W'($urandom);
      end
      #1;
      if (lat_pending) begin
        checkOutput({name, "_lat_valid"}, 64'(bus.sha_data_valid_o), 64'd1);
        checkOutput({name, "_lat_data"}, 64'(bus.sha_data_o), 64'(exp_q[0]));
        lat_pending = 1'b0;
      end
      if (prev_stall) begin
        checkOutput({name, "_hold_valid"}, 64'(bus.sha_data_valid_o), 64'd1);
        checkOutput({name, "_hold_data"}, 64'(bus.sha_data_o), 64'(prev_data));
      end
      if (bus.msg_valid_i && bus.msg_ready_o) begin
        if (wi == 0) lat_pending = 1'b1;
        wi++;
      end
      if (got_data.size() > 0 && !bus.sha_data_valid_o) bubbles++;
      if (bus.sha_data_valid_o && bus.sha_ready_i) begin
        got_data.push_back(bus.sha_data_o);
        got_last.push_back(bus.sha_last_o);
        got_start.push_back(bus.sha_start_o);
      end
      prev_stall = bus.sha_data_valid_o && !bus.sha_ready_i;
      prev_data  = bus.sha_data_o;
      cyc++;
    end

    checkOutput({name, "_beats"}, 64'(got_data.size()), 64'(exp_q.size()));
    for (int k = 0; k < got_data.size() && k < exp_q.size(); k++) begin
      checkOutput($sformatf("%s_data%0d", name, k), 64'(got_data[k]), 64'(exp_q[k]));
      checkOutput($sformatf("%s_last%0d", name, k), 64'(got_last[k]),
                  64'(k == exp_q.size() - 1));
      checkOutput($sformatf("%s_start%0d", name, k), 64'(got_start[k]), 64'(k == 0));
    end
    if (check_gap) checkOutput({name, "_bubbles"}, 64'(bubbles), 64'd0);

    // Source must stay held off until the core reports done.
    @(negedge clk_i);
    bus.sha_ready_i = 1'b1;
    bus.msg_valid_i = 1'b1;
    bus.msg_last_i  = 1'b1;
    bus.msg_bytes_i = '0;
    bus.msg_data_i  = W'($urandom);
    repeat (3) begin
      #1;
      checkOutput({name, "_wait_ready"}, 64'(bus.msg_ready_o), 64'd0);
      checkOutput({name, "_wait_busy"}, 64'(bus.busy_o), 64'd1);
      @(negedge clk_i);
    end
    bus.msg_valid_i = 1'b0;
    bus.sha_done_i  = 1'b1;
    @(negedge clk_i);
    bus.sha_done_i = 1'b0;
    #1;
    checkOutput({name, "_idle_busy"}, 64'(bus.busy_o), 64'd0);
    checkOutput({name, "_idle_ready"}, 64'(bus.msg_ready_o), 64'd1);
  endtask

  initial begin
    logic [W-1:0] abc_w0;
    abc_w0 = W'(32'h61626380) << (W - 32);

    bus.abort_i          = 1'b0;
    bus.msg_valid_i      = 1'b0;
    bus.msg_data_i       = '0;
    bus.msg_last_i       = 1'b0;
    bus.msg_bytes_i      = '0;
    bus.sha_ready_i      = 1'b0;
    bus.sha_core_ready_i = 1'b1;
    bus.sha_done_i       = 1'b0;

    #12;
    checkOutput("rst_valid", 64'(bus.sha_data_valid_o), 64'd0);
    checkOutput("rst_start", 64'(bus.sha_start_o), 64'd0);
    checkOutput("rst_last", 64'(bus.sha_last_o), 64'd0);
    checkOutput("rst_data", 64'(bus.sha_data_o), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy_o), 64'd0);
    @(negedge clk_i);
    aresetn_i = 1'b1;

    msg_q = '{8'h61, 8'h62, 8'h63};
    applyStimulus("abc", 1'b0, 1'b0, 1'b1);
    if (got_data.size() == 16) begin
      checkOutput("abc_w0_const", 64'(got_data[0]), 64'(abc_w0));
      checkOutput("abc_w15_const", 64'(got_data[15]), 64'h18);
    end

    setRandomMsg(0);
    applyStimulus("empty", 1'b0, 1'b0, 1'b1);

    setRandomMsg(14 * NB);
    applyStimulus("full14", 1'b0, 1'b0, 1'b1);

    setRandomMsg(16 * NB);
    applyStimulus("full16_stall", 1'b1, 1'b0, 1'b0);

    setRandomMsg(14 * NB + 1);
    applyStimulus("part14", 1'b1, 1'b1, 1'b0);

    setRandomMsg(15 * NB + 3);
    applyStimulus("part15", 1'b1, 1'b1, 1'b0);

    setRandomMsg(13 * NB + 2);
    applyStimulus("part13", 1'b0, 1'b0, 1'b1);

    setRandomMsg(15 * NB);
    applyStimulus("full15", 1'b1, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      setRandomMsg($urandom_range(0, 40 * NB));
      applyStimulus($sformatf("rand%0d", r), 1'b1, 1'b1, 1'b0);
    end

    // Abort in the middle of a message, then a clean message must start from word 0.
    bus.sha_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      bus.msg_valid_i = 1'b1;
      bus.msg_data_i  = W'($urandom);
      bus.msg_last_i  = 1'b0;
    end
    @(negedge clk_i);
    bus.msg_data_i = W'($urandom);
    bus.abort_i    = 1'b1;
    #1;
    checkOutput("abort_busy_before", 64'(bus.busy_o), 64'd1);
    checkOutput("abort_pass", 64'(bus.sha_abort_o), 64'd1);
    @(negedge clk_i);
    bus.abort_i     = 1'b0;
    bus.msg_valid_i = 1'b0;
    #1;
    checkOutput("abort_release", 64'(bus.sha_abort_o), 64'd0);
    checkOutput("abort_valid", 64'(bus.sha_data_valid_o), 64'd0);
    checkOutput("abort_start", 64'(bus.sha_start_o), 64'd0);
    checkOutput("abort_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("abort_ready", 64'(bus.msg_ready_o), 64'd1);

    msg_q = '{8'h61, 8'h62, 8'h63};
    applyStimulus("abort_abc", 1'b0, 1'b0, 1'b1);
    if (got_data.size() == 16) begin
      checkOutput("abort_abc_w0", 64'(got_data[0]), 64'(abc_w0));
      checkOutput("abort_abc_w15", 64'(got_data[15]), 64'h18);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
